sat_corr: RTL and testbench
===========================

Name: sat_corr

Overview:
- Receive-side counterpart of sat_chan: one GPS L1 C/A despreading channel.
- Wipes carrier off complex baseband samples with a carrier NCO and despreads with a locally generated C/A code driven by a code NCO.
- Integrates prompt I/Q over one code epoch (1023 chips) and dumps the sums.
- Sits after the sample source (sat_chan output or ADC front end); feeds acquisition/tracking firmware.

Parameters:
- SAMP_W, 16, signed width of real_in/imag_in.
- ACC_W, 32, signed width of the corr_i/corr_q accumulators.
- EPOCH_W, 16, width of epoch_cnt.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  channel run; low = idle and cleared.
- sample_valid  in  1  real_in/imag_in valid this cycle.
- real_in  in  SAMP_W  signed in-phase sample.
- imag_in  in  SAMP_W  signed quadrature sample.
- freq  in  32  carrier NCO phase increment per accepted sample.
- code_freq  in  32  code NCO phase increment per accepted sample.
- ca_sel  in  6  PRN select, 1..32.
- prompt_chip  out  1  current C/A chip, logic value.
- corr_i  out  ACC_W  dumped in-phase integral.
- corr_q  out  ACC_W  dumped quadrature integral.
- corr_valid  out  1  one-cycle strobe; corr_i/corr_q are new.
- epoch_cnt  out  EPOCH_W  completed epochs since enable rose; wraps.

Behaviour:
- Interface (already decided): one clock, clk; reset_n is asynchronous and active-low.
- Reset: all outputs 0, NCO phases 0, chip_cnt 0, accumulators 0, G1/G2 registers all-ones.
- enable low:
  - Same state as reset, applied synchronously.
  - corr_valid is never asserted while enable is low.
  - Dropping enable mid-epoch discards the partial sums.
- Sampling of controls:
  - ca_sel is sampled on the first cycle enable is high; changes while enabled are ignored.
  - freq and code_freq are used live on every accepted sample.
- Invalid ca_sel (0 or >32): code generator is bypassed and the chip is held at 0 (+1 polarity).
- Accepted sample (enable & sample_valid). Quadrant q = carr_phase[31:30], taken before the increment:
  - Mix is x·e^{-jqπ/2}, computed in SAMP_W+1 bits so negation never overflows:
    - q0: (I, Q)
    - q1: (Q, -I)
    - q2: (-I, -Q)
    - q3: (-Q, I)
  - Despread: chip 0 → ×(+1), chip 1 → ×(−1).
  - Sign-extend and add into acc_i/acc_q; wrap-around on overflow, no saturation.
  - carr_phase += freq; code_phase += code_freq (both modulo 2^32).
- Code advance:
  - A carry out of code_phase is a code tick; it advances G1/G2 one chip after the current sample is processed.
  - chip_cnt counts 0..1022.
  - A tick at chip_cnt = 1022 ends the epoch: chip_cnt → 0 and G1/G2 are reloaded to all-ones, so chip 0 is aligned.
- Dump timing:
  - The sample causing the end-of-epoch tick is included in the epoch.
  - corr_valid pulses 2 cycles after that sample's cycle (pipeline: register/mix, accumulate, dump).
  - corr_i/corr_q hold until the next dump. epoch_cnt increments in the same cycle as corr_valid.
  - Accumulators restart from the next sample with no gap or loss.
- Idle cycles: no state change except draining the pipeline.
- Simultaneous end-of-epoch with an enable drop: enable wins; no dump.
- C/A generator:
  - G1 = 1+x³+x¹⁰.
  - G2 = 1+x²+x³+x⁶+x⁸+x⁹+x¹⁰.
  - chip = G1[10] ^ G2[s1] ^ G2[s2], using the ICD-GPS-200 tap-pair table for PRN 1..32.

Decomposition:
- Package sat_pkg holds:
  - the PRN→(s1,s2) tap-pair constant table;
  - CHIPS_PER_EPOCH = 1023;
  - typedef for the complex sample struct.
- One sub-module: ca_gen (G1/G2 LFSRs, tap select, step/reload inputs, chip output). It is shared with sat_chan.

Test Plan:
1. Reset: assert reset_n=0 mid-run → all outputs 0 immediately; after release with enable=0 for 100 cycles, corr_valid never asserts.
2. Code check: ca_sel=1, code_freq=0x40000000 → prompt_chip across the first 10 chips = 1100100000. Repeat with ca_sel=2 → 1110010000.
3. Code balance: ca_sel=1, freq=0, code_freq=0x40000000, input constant (100,0), sample_valid=1 → first corr_valid after 4092 samples + 2 cycles; corr_i=-400, corr_q=0; epoch_cnt=1.
4. Carrier wipe-off: ca_sel=0, freq=0x40000000, code_freq=0x40000000, input repeating (100,0),(0,100),(-100,0),(0,-100) → corr_i=409200, corr_q=0 every epoch.
5. Gapped input: repeat case 3 with sample_valid at 1/3 duty → identical corr_i/corr_q; dump interval is 3× longer in cycles.
6. Enable drop: enable low at sample 2000 of an epoch, high again later → no dump for the partial epoch; epoch_cnt restarts at 0; next dump equals case 3 values.

Source files
------------

// File: rtl/sat_pkg.sv
// Shared constants for the GPS L1 C/A channel blocks (sat_chan transmit, sat_corr receive).
// Holds the PRN tap-pair table, epoch length and the complex sample type.
package sat_pkg;

   localparam int CHIPS_PER_EPOCH = 1023;
   localparam int SAMP_W_DEF      = 16;

   typedef struct packed {
      logic signed [SAMP_W_DEF-1:0] re;
      logic signed [SAMP_W_DEF-1:0] im;
   } cplx_samp_t;

   // G2 phase-selector tap pairs {s1,s2} for PRN 1..32, one nibble each, index = PRN-1.
   localparam logic [7:0] PRN_TAPS [32] = '{
      8'h26, 8'h37, 8'h48, 8'h59, 8'h19, 8'h2A, 8'h18, 8'h29,
      8'h3A, 8'h23, 8'h34, 8'h56, 8'h67, 8'h78, 8'h89, 8'h9A,
      8'h14, 8'h25, 8'h36, 8'h47, 8'h58, 8'h69, 8'h13, 8'h46,
      8'h57, 8'h68, 8'h79, 8'h8A, 8'h16, 8'h27, 8'h38, 8'h49
   };

endpackage

// File: rtl/ca_gen.sv
// GPS C/A code generator: G1/G2 ten-stage LFSRs with PRN tap selection.
// Chip is 0 for an out-of-range PRN so the caller sees an unmodulated +1 code.
module ca_gen
   import sat_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       i_clear,
   input  logic [5:0] i_prn,
   input  logic       i_step,
   input  logic       i_reload,
   output logic       o_chip
);

   logic [10:1] r_g1;
   logic [10:1] r_g2;
   logic        w_prn_ok;
   logic [7:0]  w_taps;
   logic [3:0]  w_s1;
   logic [3:0]  w_s2;
   logic        w_g1_fb;
   logic        w_g2_fb;

   assign w_prn_ok = (i_prn >= 6'd1) && (i_prn <= 6'd32);
   assign w_taps   = w_prn_ok ? PRN_TAPS[5'(i_prn - 6'd1)] : 8'h11;
   assign w_s1     = w_taps[7:4];
   assign w_s2     = w_taps[3:0];

   assign w_g1_fb  = r_g1[3] ^ r_g1[10];
   assign w_g2_fb  = r_g2[2] ^ r_g2[3] ^ r_g2[6] ^ r_g2[8] ^ r_g2[9] ^ r_g2[10];

   assign o_chip   = w_prn_ok & (r_g1[10] ^ r_g2[w_s1] ^ r_g2[w_s2]);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_g1 <= '1;
         r_g2 <= '1;
      end else if (i_clear || i_reload) begin
         r_g1 <= '1;
         r_g2 <= '1;
      end else if (i_step) begin
         r_g1 <= {r_g1[9:1], w_g1_fb};
         r_g2 <= {r_g2[9:1], w_g2_fb};
      end
   end

endmodule

// File: rtl/sat_corr.sv
// GPS L1 C/A receive channel: carrier wipe-off, prompt despread and per-epoch I/Q integrate-and-dump.
// Pipeline: mix/despread register -> accumulate -> dump, so corr_valid trails the last epoch sample by 2 cycles.
module sat_corr
   import sat_pkg::*;
#(
   parameter int SAMP_W  = 16,
   parameter int ACC_W   = 32,
   parameter int EPOCH_W = 16
)
(
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     enable,
   input  logic                     sample_valid,
   input  logic signed [SAMP_W-1:0] real_in,
   input  logic signed [SAMP_W-1:0] imag_in,
   input  logic [31:0]              freq,
   input  logic [31:0]              code_freq,
   input  logic [5:0]               ca_sel,
   output logic                     prompt_chip,
   output logic signed [ACC_W-1:0]  corr_i,
   output logic signed [ACC_W-1:0]  corr_q,
   output logic                     corr_valid,
   output logic [EPOCH_W-1:0]       epoch_cnt
);

   localparam int MIX_W = SAMP_W + 1;

   logic                    r_started;
   logic [5:0]              r_prn;
   logic [31:0]             r_carr;
   logic [31:0]             r_code;
   logic [9:0]              r_chip_cnt;
   logic                    r_mix_vld;
   logic                    r_mix_eoe;
   logic signed [MIX_W-1:0] r_mix_i;
   logic signed [MIX_W-1:0] r_mix_q;
   logic signed [ACC_W-1:0] r_acc_i;
   logic signed [ACC_W-1:0] r_acc_q;
   logic                    r_dump_pend;

   logic                    w_accept;
   logic [5:0]              w_prn;
   logic [32:0]             w_code_sum;
   logic                    w_tick;
   logic                    w_eoe;
   logic                    w_chip;
   logic signed [MIX_W-1:0] w_i;
   logic signed [MIX_W-1:0] w_q;
   logic signed [MIX_W-1:0] w_rot_i;
   logic signed [MIX_W-1:0] w_rot_q;
   logic signed [MIX_W-1:0] w_dsp_i;
   logic signed [MIX_W-1:0] w_dsp_q;
   logic signed [ACC_W-1:0] w_ext_i;
   logic signed [ACC_W-1:0] w_ext_q;

   assign w_accept   = enable & sample_valid;
   // PRN is taken straight from ca_sel on the first enabled cycle, then from the latched copy.
   assign w_prn      = (reset_n & enable) ? (r_started ? r_prn : ca_sel) : 6'd0;
   assign w_code_sum = {1'b0, r_code} + {1'b0, code_freq};
   assign w_tick     = w_accept & w_code_sum[32];
   assign w_eoe      = w_tick & (r_chip_cnt == 10'(CHIPS_PER_EPOCH - 1));

   ca_gen u_ca_gen (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_clear  (!enable),
      .i_prn    (w_prn),
      .i_step   (w_tick),
      .i_reload (w_eoe),
      .o_chip   (w_chip)
   );

   assign prompt_chip = w_chip;

   assign w_i = {real_in[SAMP_W-1], real_in};
   assign w_q = {imag_in[SAMP_W-1], imag_in};

   always_comb begin
      w_rot_i = w_i;
      w_rot_q = w_q;
      unique case (r_carr[31:30])
         2'd0: begin w_rot_i = w_i;  w_rot_q = w_q;  end
         2'd1: begin w_rot_i = w_q;  w_rot_q = -w_i; end
         2'd2: begin w_rot_i = -w_i; w_rot_q = -w_q; end
         2'd3: begin w_rot_i = -w_q; w_rot_q = w_i;  end
      endcase
   end

   assign w_dsp_i = w_chip ? -w_rot_i : w_rot_i;
   assign w_dsp_q = w_chip ? -w_rot_q : w_rot_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_started  <= 1'b0;
         r_prn      <= '0;
         r_carr     <= '0;
         r_code     <= '0;
         r_chip_cnt <= '0;
         r_mix_vld  <= 1'b0;
         r_mix_eoe  <= 1'b0;
         r_mix_i    <= '0;
         r_mix_q    <= '0;
      end else if (!enable) begin
         r_started  <= 1'b0;
         r_prn      <= '0;
         r_carr     <= '0;
         r_code     <= '0;
         r_chip_cnt <= '0;
         r_mix_vld  <= 1'b0;
         r_mix_eoe  <= 1'b0;
         r_mix_i    <= '0;
         r_mix_q    <= '0;
      end else begin
         if (!r_started) begin
            r_started <= 1'b1;
            r_prn     <= ca_sel;
         end
         r_mix_vld <= w_accept;
         r_mix_eoe <= w_eoe;
         if (w_accept) begin
            r_mix_i <= w_dsp_i;
            r_mix_q <= w_dsp_q;
            r_carr  <= r_carr + freq;
            r_code  <= w_code_sum[31:0];
            if (w_tick) begin
               r_chip_cnt <= w_eoe ? 10'd0 : r_chip_cnt + 10'd1;
            end
         end
      end
   end

   assign w_ext_i = {{(ACC_W-MIX_W){r_mix_i[MIX_W-1]}}, r_mix_i};
   assign w_ext_q = {{(ACC_W-MIX_W){r_mix_q[MIX_W-1]}}, r_mix_q};

   // On a dump the next epoch's first sample seeds the accumulator so nothing is lost.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_acc_i     <= '0;
         r_acc_q     <= '0;
         r_dump_pend <= 1'b0;
         corr_i      <= '0;
         corr_q      <= '0;
         corr_valid  <= 1'b0;
         epoch_cnt   <= '0;
      end else if (!enable) begin
         r_acc_i     <= '0;
         r_acc_q     <= '0;
         r_dump_pend <= 1'b0;
         corr_i      <= '0;
         corr_q      <= '0;
         corr_valid  <= 1'b0;
         epoch_cnt   <= '0;
      end else begin
         r_dump_pend <= r_mix_vld & r_mix_eoe;
         corr_valid  <= r_dump_pend;
         if (r_dump_pend) begin
            corr_i    <= r_acc_i;
            corr_q    <= r_acc_q;
            epoch_cnt <= epoch_cnt + EPOCH_W'(1);
            r_acc_i   <= r_mix_vld ? w_ext_i : '0;
            r_acc_q   <= r_mix_vld ? w_ext_q : '0;
         end else if (r_mix_vld) begin
            r_acc_i   <= r_acc_i + w_ext_i;
            r_acc_q   <= r_acc_q + w_ext_q;
         end
      end
   end

endmodule

// File: tb/tb_sat_corr.sv
// Bench for sat_corr: sample-level reference model of the channel checked every cycle,
// plus literal expectations for code sequences, epoch sums and dump timing.
module tb_sat_corr;

   logic               clk;
   logic               reset_n;
   logic               enable;
   logic               sample_valid;
   logic signed [15:0] real_in;
   logic signed [15:0] imag_in;
   logic [31:0]        freq;
   logic [31:0]        code_freq;
   logic [5:0]         ca_sel;
   logic               prompt_chip;
   logic signed [31:0] corr_i;
   logic signed [31:0] corr_q;
   logic               corr_valid;
   logic [15:0]        epoch_cnt;

   sat_corr dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (enable),
      .sample_valid (sample_valid),
      .real_in      (real_in),
      .imag_in      (imag_in),
      .freq         (freq),
      .code_freq    (code_freq),
      .ca_sel       (ca_sel),
      .prompt_chip  (prompt_chip),
      .corr_i       (corr_i),
      .corr_q       (corr_q),
      .corr_valid   (corr_valid),
      .epoch_cnt    (epoch_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   bit chk_on = 0;
   int edge_n = 0;

   // reference C/A sequences, built from the G1/G2 definitions
   bit ca_tab [0:32][0:1022];
   int tap1 [1:32] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
   int tap2 [1:32] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};

   // model state
   bit        m_started;
   int        m_prn;
   bit [31:0] m_carr;
   bit [31:0] m_code;
   int        m_idx;
   int        m_acc_i, m_acc_q;
   bit        p1_v, p2_v;
   int        p1_i, p1_q, p2_i, p2_q;
   bit        exp_valid;
   int        exp_i, exp_q, exp_epoch;

   // observed dumps
   int dump_cnt = 0;
   int last_i, last_q, last_epoch, last_edge;

   task automatic check(input string nm, input logic signed [63:0] act, input logic signed [63:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
      end
   endtask

   task automatic build_codes();
      bit g1 [1:10];
      bit g2 [1:10];
      bit f1, f2;
      for (int p = 1; p <= 32; p++) begin
         for (int k = 1; k <= 10; k++) begin g1[k] = 1; g2[k] = 1; end
         for (int n = 0; n < 1023; n++) begin
            ca_tab[p][n] = g1[10] ^ g2[tap1[p]] ^ g2[tap2[p]];
            f1 = g1[3] ^ g1[10];
            f2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
            for (int k = 10; k >= 2; k--) begin g1[k] = g1[k-1]; g2[k] = g2[k-1]; end
            g1[1] = f1;
            g2[1] = f2;
         end
      end
   endtask

   function automatic bit model_chip(input int prn, input int idx);
      if (prn < 1 || prn > 32) return 1'b0;
      return ca_tab[prn][idx];
   endfunction

   task automatic model_clear();
      m_started = 0; m_prn = 0; m_carr = 0; m_code = 0; m_idx = 0;
      m_acc_i = 0; m_acc_q = 0;
      p1_v = 0; p2_v = 0; p1_i = 0; p1_q = 0; p2_i = 0; p2_q = 0;
      exp_valid = 0; exp_i = 0; exp_q = 0; exp_epoch = 0;
   endtask

   // One clock edge of the channel at sample level.
   task automatic model_edge(input bit en, input bit sv, input int re, input int im, input int sel);
      int cs [4] = '{1, 0, -1, 0};
      int sn [4] = '{0, 1, 0, -1};
      int q, mi, mq, sgn;
      bit [32:0] csum;
      if (!reset_n || !en) begin
         model_clear();
         return;
      end
      exp_valid = 0;
      if (p2_v) begin
         exp_valid = 1; exp_i = p2_i; exp_q = p2_q; exp_epoch++;
      end
      p2_v = p1_v; p2_i = p1_i; p2_q = p1_q;
      p1_v = 0;
      if (!m_started) begin m_started = 1; m_prn = sel; end
      if (sv) begin
         q   = int'(m_carr[31:30]);
         mi  = re * cs[q] + im * sn[q];
         mq  = im * cs[q] - re * sn[q];
         sgn = model_chip(m_prn, m_idx) ? -1 : 1;
         m_acc_i += sgn * mi;
         m_acc_q += sgn * mq;
         m_carr  += freq;
         csum     = {1'b0, m_code} + {1'b0, code_freq};
         m_code   = csum[31:0];
         if (csum[32]) begin
            m_idx++;
            if (m_idx == 1023) begin
               m_idx = 0;
               p1_v = 1; p1_i = m_acc_i; p1_q = m_acc_q;
               m_acc_i = 0; m_acc_q = 0;
            end
         end
      end
   endtask

   task automatic cyc(input bit en, input bit sv, input int re, input int im);
      enable       = en;
      sample_valid = sv;
      real_in      = 16'(re);
      imag_in      = 16'(im);
      @(posedge clk);
      model_edge(en, sv, re, im, int'(ca_sel));
      edge_n++;
      #1;
   endtask

   // per-cycle comparison against the model
   always @(negedge clk) begin
      int prn_eff;
      if (chk_on) begin
         prn_eff = (!reset_n || !enable) ? 0 : (m_started ? m_prn : int'(ca_sel));
         check("corr_valid", corr_valid, exp_valid);
         check("corr_i", corr_i, exp_i);
         check("corr_q", corr_q, exp_q);
         check("epoch_cnt", epoch_cnt, exp_epoch & 16'hFFFF);
         check("prompt_chip", prompt_chip, model_chip(prn_eff, m_idx));
         if (corr_valid === 1'b1) begin
            dump_cnt++;
            last_i = corr_i; last_q = corr_q;
            last_epoch = int'(epoch_cnt); last_edge = edge_n;
         end
      end
   end

   initial begin
      logic [9:0] bits;
      int d0, start;

      reset_n = 1'b0; enable = 0; sample_valid = 0; real_in = 0; imag_in = 0;
      freq = 0; code_freq = 0; ca_sel = 0;
      build_codes();
      model_clear();

      bits = '0;
      for (int n = 0; n < 10; n++) bits = {bits[8:0], ca_tab[1][n]};
      check("model_prn1_chips", bits, 10'b1100100000);
      bits = '0;
      for (int n = 0; n < 10; n++) bits = {bits[8:0], ca_tab[2][n]};
      check("model_prn2_chips", bits, 10'b1110010000);

      repeat (3) cyc(0, 0, 0, 0);
      reset_n = 1'b1;
      chk_on  = 1;
      cyc(0, 0, 0, 0);

      // PRN 1 code sequence, 4 samples per chip
      ca_sel = 6'd1; freq = 0; code_freq = 32'h4000_0000;
      bits = '0;
      for (int c = 0; c < 10; c++) begin
         enable = 1; sample_valid = 1; real_in = 100; imag_in = 0;
         #1;
         bits = {bits[8:0], prompt_chip};
         repeat (4) cyc(1, 1, 100, 0);
      end
      check("prn1_chips", bits, 10'b1100100000);

      // asynchronous reset mid-run
      reset_n = 1'b0;
      #1;
      check("rst_corr_valid", corr_valid, 0);
      check("rst_corr_i", corr_i, 0);
      check("rst_corr_q", corr_q, 0);
      check("rst_epoch_cnt", epoch_cnt, 0);
      check("rst_prompt_chip", prompt_chip, 0);
      model_clear();
      repeat (3) cyc(0, 0, 0, 0);
      reset_n = 1'b1;
      d0 = dump_cnt;
      repeat (100) cyc(0, 1, 55, -55);
      check("idle_no_dump", dump_cnt - d0, 0);

      // PRN 2 code sequence
      ca_sel = 6'd2;
      bits = '0;
      for (int c = 0; c < 10; c++) begin
         enable = 1; sample_valid = 1; real_in = 100; imag_in = 0;
         #1;
         bits = {bits[8:0], prompt_chip};
         repeat (4) cyc(1, 1, 100, 0);
      end
      check("prn2_chips", bits, 10'b1110010000);
      cyc(0, 0, 0, 0);

      // code balance, one full epoch
      ca_sel = 6'd1; freq = 0; code_freq = 32'h4000_0000;
      d0 = dump_cnt; start = edge_n + 1;
      repeat (4092 + 4) cyc(1, 1, 100, 0);
      check("bal_dumps", dump_cnt - d0, 1);
      check("bal_corr_i", last_i, -400);
      check("bal_corr_q", last_q, 0);
      check("bal_epoch", last_epoch, 1);
      check("bal_latency", last_edge - start, 4093);
      check("bal_model_i", exp_i, -400);
      cyc(0, 0, 0, 0);

      // carrier wipe-off with invalid PRN, two epochs
      ca_sel = 6'd0; freq = 32'h4000_0000; code_freq = 32'h4000_0000;
      d0 = dump_cnt;
      for (int n = 0; n < 2 * 4092 + 4; n++) begin
         case (n % 4)
            0: cyc(1, 1, 100, 0);
            1: cyc(1, 1, 0, 100);
            2: cyc(1, 1, -100, 0);
            default: cyc(1, 1, 0, -100);
         endcase
      end
      check("wipe_dumps", dump_cnt - d0, 2);
      check("wipe_corr_i", last_i, 409200);
      check("wipe_corr_q", last_q, 0);
      check("wipe_epoch", last_epoch, 2);
      check("wipe_model_i", exp_i, 409200);
      cyc(0, 0, 0, 0);

      // gapped input at 1/3 duty
      ca_sel = 6'd1; freq = 0; code_freq = 32'h4000_0000;
      d0 = dump_cnt; start = edge_n + 1;
      for (int n = 0; n < 3 * 4092 + 10; n++) cyc(1, (n % 3) == 0, 100, 0);
      check("gap_dumps", dump_cnt - d0, 1);
      check("gap_corr_i", last_i, -400);
      check("gap_corr_q", last_q, 0);
      check("gap_latency", last_edge - start, 3 * 4091 + 2);
      cyc(0, 0, 0, 0);

      // enable drop mid-epoch discards the partial sums
      ca_sel = 6'd1; freq = 0; code_freq = 32'h4000_0000;
      d0 = dump_cnt;
      repeat (2000) cyc(1, 1, 100, 0);
      repeat (20) cyc(0, 1, 100, 0);
      check("drop_no_dump", dump_cnt - d0, 0);
      repeat (4092 + 4) cyc(1, 1, 100, 0);
      check("drop_dumps", dump_cnt - d0, 1);
      check("drop_corr_i", last_i, -400);
      check("drop_corr_q", last_q, 0);
      check("drop_epoch", last_epoch, 1);
      cyc(0, 0, 0, 0);

      chk_on = 0;
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
